// File: rtl/multi_pulse_generator_pkg.sv
// Shared types for the multi-channel pulse generator (package pulse_gen_pkg).
// The optional LED stretch width is only used when PULSE_GEN_LED_EN is defined.
package pulse_gen_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} pg_state_t;

  localparam int PG_LED_STRETCH_W = 22;

endpackage

// File: rtl/multi_pulse_generator_channel.sv
// One pulse-train channel: delay, then rep pulses of width W separated by gap G.
// Optional LED outputs (stretched pulse, delay indicator) under PULSE_GEN_LED_EN.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REP_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] gap_i,
  input  logic [REP_W-1:0] rep_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
`ifdef PULSE_GEN_LED_EN
  ,
  output logic             pulse_led_o,
  output logic             delay_led_o
`endif
);

  pg_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] pcnt_q, pcnt_d;
  logic             pulse_q, busy_q, done_q;
  logic             pulse_d;
  logic             cancel, accept, is_last;

  // Outputs trail the FSM by one register stage; busy_q stays high for the
  // completion cycle, so the channel counts as active until its last pulse has fallen.
  assign cancel  = stop_i && ((state_q != IDLE) || busy_q);
  assign accept  = start_i && !stop_i && (state_q == IDLE) && !busy_q;
  assign is_last = (rep_q != '0) && (pcnt_q == rep_q - REP_W'(1));
  assign pulse_d = (state_q == HIGH) && !cancel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    gap_d   = gap_q;
    rep_d   = rep_q;
    pcnt_d  = pcnt_q;
    if (cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // The delay goes straight into the down-counter; width/gap are kept clamped to >= 1.
            wid_d  = (width_i == '0) ? CNT_W'(1) : width_i;
            gap_d  = (gap_i == '0) ? CNT_W'(1) : gap_i;
            rep_d  = rep_i;
            pcnt_d = '0;
            if (delay_i == '0) begin
              state_d = HIGH;
              cnt_d   = wid_d - CNT_W'(1);
            end else begin
              state_d = DELAY;
              cnt_d   = delay_i - CNT_W'(1);
            end
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d = HIGH;
            cnt_d   = wid_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            pcnt_d = (pcnt_q == '1) ? pcnt_q : pcnt_q + REP_W'(1);
            if (is_last) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              cnt_d   = gap_q - CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = HIGH;
            cnt_d   = wid_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wid_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wid_q   <= wid_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      busy_q  <= (state_q != IDLE) && !cancel;
      // IDLE with busy_q still set only happens right after a normal completion.
      done_q  <= (state_q == IDLE) && busy_q && !cancel;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

`ifdef PULSE_GEN_LED_EN
  logic [PG_LED_STRETCH_W-1:0] str_q, str_d;

  // Reload on each rising pulse; count down only once the pulse is low so the LED
  // stays lit for at least 2^PG_LED_STRETCH_W cycles.
  always_comb begin
    str_d = str_q;
    if (pulse_d && !pulse_q) begin
      str_d = '1;
    end else if (!pulse_q && (str_q != '0)) begin
      str_d = str_q - PG_LED_STRETCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      str_q <= '0;
    end else begin
      str_q <= str_d;
    end
  end

  assign pulse_led_o = pulse_q || (str_q != '0);
  assign delay_led_o = (state_q == DELAY);
`endif

endmodule

// File: rtl/multi_pulse_generator.sv
// NUM_CH independent pulse-train channels sharing one clock and reset.
// LED outputs exist only when PULSE_GEN_LED_EN is defined.
module multi_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int REP_W  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH*CNT_W-1:0] delay_cycles,
  input  logic [NUM_CH*CNT_W-1:0] pulse_width_cycles,
  input  logic [NUM_CH*CNT_W-1:0] gap_cycles,
  input  logic [NUM_CH*REP_W-1:0] repetition,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
`ifdef PULSE_GEN_LED_EN
  ,
  output logic [NUM_CH-1:0]       pulse_led,
  output logic [NUM_CH-1:0]       delay_led
`endif
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pulse_channel #(
        .CNT_W(CNT_W),
        .REP_W(REP_W)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start[gi]),
        .stop_i     (stop[gi]),
        .delay_i    (delay_cycles[gi*CNT_W +: CNT_W]),
        .width_i    (pulse_width_cycles[gi*CNT_W +: CNT_W]),
        .gap_i      (gap_cycles[gi*CNT_W +: CNT_W]),
        .rep_i      (repetition[gi*REP_W +: REP_W]),
        .pulse_o    (pulse_out[gi]),
        .busy_o     (busy[gi]),
        .done_o     (done[gi])
`ifdef PULSE_GEN_LED_EN
        ,
        .pulse_led_o(pulse_led[gi]),
        .delay_led_o(delay_led[gi])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed plus randomized bench for multi_pulse_generator against a timeline model.
module tb_multi_pulse_generator;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int RW  = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic [NCH-1:0]     start, stop;
  logic [NCH*CW-1:0]  delay_cycles, pulse_width_cycles, gap_cycles;
  logic [NCH*RW-1:0]  repetition;
  logic [NCH-1:0]     pulse_out, busy, done;
`ifdef PULSE_GEN_LED_EN
  logic [NCH-1:0]     pulse_led, delay_led;
`endif

  always #10 clk = ~clk;

  multi_pulse_generator #(.NUM_CH(NCH), .CNT_W(CW), .REP_W(RW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .stop              (stop),
    .delay_cycles      (delay_cycles),
    .pulse_width_cycles(pulse_width_cycles),
    .gap_cycles        (gap_cycles),
    .repetition        (repetition),
    .pulse_out         (pulse_out),
    .busy              (busy),
    .done              (done)
`ifdef PULSE_GEN_LED_EN
    ,
    .pulse_led         (pulse_led),
    .delay_led         (delay_led)
`endif
  );

  int     vectors = 0;
  int     miscompares = 0;
  longint t = 0;

  // Per-channel train description: start edge, latched parameters, edge of last fall.
  bit     m_run [NCH];
  longint m_t0  [NCH];
  longint m_f   [NCH];
  int     m_d   [NCH];
  int     m_w   [NCH];
  int     m_g   [NCH];
  int     m_r   [NCH];

  task automatic set_ch(input int ch, input int d, input int w, input int g, input int r);
    delay_cycles[ch*CW +: CW]       = CW'(d);
    pulse_width_cycles[ch*CW +: CW] = CW'(w);
    gap_cycles[ch*CW +: CW]         = CW'(g);
    repetition[ch*RW +: RW]         = RW'(r);
  endtask

  function automatic bit exp_pulse(input int ch);
    longint k, n, r, p;
    k = t - (m_t0[ch] + m_d[ch] + 1);
    if (k < 0) return 1'b0;
    p = m_w[ch] + m_g[ch];
    n = k / p;
    r = k % p;
    return (r < m_w[ch]) && ((m_r[ch] == 0) || (n < m_r[ch]));
  endfunction

  task automatic model_edge();
    for (int ch = 0; ch < NCH; ch++) begin
      if (reset) begin
        m_run[ch] = 1'b0;
      end else if (m_run[ch] && stop[ch] && (t > m_t0[ch]) && (t <= m_f[ch])) begin
        m_run[ch] = 1'b0;
      end else if (start[ch] && !stop[ch] && (!m_run[ch] || (t > m_f[ch]))) begin
        m_run[ch] = 1'b1;
        m_t0[ch]  = t;
        m_d[ch]   = int'(delay_cycles[ch*CW +: CW]);
        m_w[ch]   = int'(pulse_width_cycles[ch*CW +: CW]);
        m_g[ch]   = int'(gap_cycles[ch*CW +: CW]);
        m_r[ch]   = int'(repetition[ch*RW +: RW]);
        if (m_w[ch] == 0) m_w[ch] = 1;
        if (m_g[ch] == 0) m_g[ch] = 1;
        if (m_r[ch] == 0)
          m_f[ch] = 64'h7fff_ffff_ffff_ffff;
        else
          m_f[ch] = m_t0[ch] + m_d[ch] + 1 + longint'(m_r[ch] - 1) * (m_w[ch] + m_g[ch]) + m_w[ch];
      end
    end
  endtask

  task automatic check();
    logic [NCH-1:0] ep, eb, ed;
    ep = '0; eb = '0; ed = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (m_run[ch]) begin
        ep[ch] = exp_pulse(ch);
        eb[ch] = (t >= m_t0[ch] + 1) && (t < m_f[ch]);
        ed[ch] = (t == m_f[ch]);
      end
    end
    vectors++;
    assert (pulse_out === ep) else begin
      miscompares++;
      $error("FAIL pulse_out edge=%0d got=%b exp=%b", t, pulse_out, ep);
    end
    vectors++;
    assert (busy === eb) else begin
      miscompares++;
      $error("FAIL busy edge=%0d got=%b exp=%b", t, busy, eb);
    end
    vectors++;
    assert (done === ed) else begin
      miscompares++;
      $error("FAIL done edge=%0d got=%b exp=%b", t, done, ed);
    end
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    model_edge();
    #1;
    check();
  endtask

  initial begin
    reset = 1'b1;
    start = '0;
    stop  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      set_ch(ch, 0, 0, 0, 0);
      m_run[ch] = 1'b0;
      m_t0[ch] = 0; m_f[ch] = 0;
      m_d[ch] = 0; m_w[ch] = 1; m_g[ch] = 1; m_r[ch] = 0;
    end
    // Reset state
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Channel 0: D=10 W=20 G=5 rep=3
    set_ch(0, 10, 20, 5, 3);
    start[0] = 1'b1; step(); start = '0;
    set_ch(0, 1, 2, 3, 1);  // must not disturb the running train
    repeat (90) step();

    // Zero delay/width/gap are clamped
    set_ch(0, 0, 0, 0, 2);
    start[0] = 1'b1; step(); start = '0;
    repeat (8) step();

    // Infinite train, then stop
    set_ch(1, 3, 4, 4, 0);
    start[1] = 1'b1; step(); start = '0;
    repeat (1000) step();
    stop[1] = 1'b1; step(); stop = '0;
    repeat (5) step();

    // All channels together, then a re-issued start with changed inputs
    set_ch(0, 2, 3, 2, 4);
    set_ch(1, 5, 1, 1, 3);
    set_ch(2, 0, 6, 3, 2);
    set_ch(3, 8, 2, 4, 5);
    start = '1; step(); start = '0;
    repeat (9) step();
    for (int ch = 0; ch < NCH; ch++) set_ch(ch, 1, 1, 1, 1);
    start = '1; step(); start = '0;
    repeat (60) step();

    // Reset in the middle of a pulse
    set_ch(2, 2, 8, 2, 1);
    start[2] = 1'b1; step(); start = '0;
    repeat (5) step();
    reset = 1'b1; step(); reset = 1'b0;
    repeat (3) step();

    // Start and stop together while idle
    set_ch(3, 1, 2, 2, 2);
    start[3] = 1'b1; stop[3] = 1'b1; step();
    start = '0; stop = '0;
    repeat (5) step();

    // Randomized traffic with inputs changing every cycle
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        set_ch(ch, int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        start[ch] = ($urandom_range(0, 7) == 0);
        stop[ch]  = ($urandom_range(0, 40) == 0);
      end
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    start = '0; stop = '0; reset = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
